// File: rtl/axi_lite_manager_v2.sv
// AXI4-Lite manager for the RV32I memory port: one transaction in flight,
// valid/ready request side, independent AW/W completion, B/R handshakes,
// response reporting and a saturating error counter.
module axi_lite_manager_v2 #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter logic [2:0]  PROT          = 3'b000,
  parameter int unsigned ERR_CNT_WIDTH = 8,
  localparam int unsigned STRB_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [STRB_WIDTH-1:0]    req_wstrb,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic [1:0]               resp_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    axi_awaddr,
  output logic [2:0]               axi_awprot,
  output logic                     axi_awvalid,
  input  logic                     axi_awready,
  output logic [DATA_WIDTH-1:0]    axi_wdata,
  output logic [STRB_WIDTH-1:0]    axi_wstrb,
  output logic                     axi_wvalid,
  input  logic                     axi_wready,
  input  logic [1:0]               axi_bresp,
  input  logic                     axi_bvalid,
  output logic                     axi_bready,
  output logic [ADDR_WIDTH-1:0]    axi_araddr,
  output logic [2:0]               axi_arprot,
  output logic                     axi_arvalid,
  input  logic                     axi_arready,
  input  logic [DATA_WIDTH-1:0]    axi_rdata,
  input  logic [1:0]               axi_rresp,
  input  logic                     axi_rvalid,
  output logic                     axi_rready
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    WRITE_RESP = 3'd2,
    READ_ADDR  = 3'd3,
    READ_RESP  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]    wstrb_q, wstrb_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     bready_q, bready_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q, rready_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [1:0]               resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

  logic aw_hs, w_hs, aw_fin, w_fin;

  assign aw_hs  = awvalid_q & axi_awready;
  assign w_hs   = wvalid_q & axi_wready;
  // Same-cycle completion of the second channel counts as done.
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;

  function automatic logic [ERR_CNT_WIDTH-1:0] err_next(
    input logic [ERR_CNT_WIDTH-1:0] cnt,
    input logic [1:0]               resp
  );
    if (resp[1] && (cnt != '1)) return cnt + ERR_CNT_WIDTH'(1);
    return cnt;
  endfunction

  // Next-state and next-register values for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    err_count_d  = err_count_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (req_we) begin
            wdata_d   = req_wdata;
            wstrb_d   = req_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = READ_ADDR;
          end
        end
      end
      WRITE: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) begin
          bready_d = 1'b1;
          state_d  = WRITE_RESP;
        end
      end
      WRITE_RESP: begin
        if (axi_bvalid && bready_q) begin
          bready_d     = 1'b0;
          resp_err_d   = axi_bresp;
          resp_valid_d = 1'b1;
          err_count_d  = err_next(err_count_q, axi_bresp);
          state_d      = IDLE;
        end
      end
      READ_ADDR: begin
        if (arvalid_q && axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = READ_RESP;
        end
      end
      READ_RESP: begin
        if (axi_rvalid && rready_q) begin
          rready_d     = 1'b0;
          resp_rdata_d = axi_rdata;
          resp_err_d   = axi_rresp;
          resp_valid_d = 1'b1;
          err_count_d  = err_next(err_count_q, axi_rresp);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= '0;
      resp_rdata_q <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      err_count_q  <= err_count_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign err_count   = err_count_q;
  assign axi_awaddr  = addr_q;
  assign axi_awprot  = PROT;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;
  assign axi_araddr  = addr_q;
  assign axi_arprot  = PROT;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_manager_v2.sv
// Bench for axi_lite_manager_v2: configurable-delay AXI4-Lite subordinate,
// table vectors, hand sequences and randomized transactions against a
// transaction-level model (latency, response, saturating error count).
module tb_axi_lite_manager_v2;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned EW = 8;
  localparam logic [2:0]  PROT_V = 3'b000;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic [1:0]    resp_err;
  logic [EW-1:0] err_count;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic [2:0]    axi_awprot, axi_arprot;
  logic          axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [DW-1:0] axi_wdata, axi_rdata;
  logic [SW-1:0] axi_wstrb;
  logic [1:0]    axi_bresp, axi_rresp;
  logic          axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic          axi_rvalid, axi_rready;

  always #5 clk = ~clk;

  axi_lite_manager_v2 #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT(PROT_V), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .err_count(err_count),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int unsigned   awd, wd, bd, ard, rd;
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
    int unsigned   lat;
  } txn_t;

  txn_t cur;

  // ---------------- subordinate model ----------------
  int unsigned aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  logic aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
  logic noise_b = 0, noise_r = 0;
  int unsigned n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, viol = 0;
  logic [AW-1:0] cap_awaddr, cap_araddr, hold_awaddr, hold_araddr;
  logic [DW-1:0] cap_wdata, hold_wdata;
  logic [SW-1:0] cap_wstrb, hold_wstrb;
  logic [2:0]    cap_awprot, cap_arprot;
  logic aw_hold = 0, w_hold = 0, ar_hold = 0;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_now, w_now;

  assign axi_awready = axi_awvalid && (aw_cnt >= cur.awd);
  assign axi_wready  = axi_wvalid  && (w_cnt  >= cur.wd);
  assign axi_arready = axi_arvalid && (ar_cnt >= cur.ard);
  assign axi_bvalid  = (b_pend && (b_cnt >= cur.bd)) || noise_b;
  assign axi_bresp   = b_pend ? cur.resp : 2'b11;
  assign axi_rvalid  = (r_pend && (r_cnt >= cur.rd)) || noise_r;
  assign axi_rresp   = r_pend ? cur.resp : 2'b11;
  assign axi_rdata   = r_pend ? cur.rdata : '1;
  assign aw_hs  = axi_awvalid && axi_awready;
  assign w_hs   = axi_wvalid && axi_wready;
  assign ar_hs  = axi_arvalid && axi_arready;
  assign b_hs   = axi_bvalid && axi_bready;
  assign r_hs   = axi_rvalid && axi_rready;
  assign aw_now = aw_got || aw_hs;
  assign w_now  = w_got || w_hs;

  always @(posedge clk) begin
    if (reset) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
      aw_hold <= 0; w_hold <= 0; ar_hold <= 0;
    end else begin
      aw_cnt <= (axi_awvalid && !axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (axi_wvalid && !axi_wready) ? w_cnt + 1 : 0;
      ar_cnt <= (axi_arvalid && !axi_arready) ? ar_cnt + 1 : 0;
      if (aw_hs) begin n_aw <= n_aw + 1; cap_awaddr <= axi_awaddr; cap_awprot <= axi_awprot; end
      if (w_hs)  begin n_w <= n_w + 1; cap_wdata <= axi_wdata; cap_wstrb <= axi_wstrb; end
      if (aw_now && w_now) begin
        b_pend <= 1; b_cnt <= 0; aw_got <= 0; w_got <= 0;
      end else begin
        aw_got <= aw_now; w_got <= w_now;
      end
      if (b_hs) n_b <= n_b + 1;
      if (b_pend) begin
        if (b_hs) b_pend <= 0; else b_cnt <= b_cnt + 1;
      end
      if (ar_hs) begin
        n_ar <= n_ar + 1; cap_araddr <= axi_araddr; cap_arprot <= axi_arprot;
        r_pend <= 1; r_cnt <= 0;
      end
      if (r_hs) n_r <= n_r + 1;
      if (r_pend) begin
        if (r_hs) r_pend <= 0; else r_cnt <= r_cnt + 1;
      end
      // a pending valid must stay high with stable payload until accepted
      if (aw_hold && (!axi_awvalid || axi_awaddr != hold_awaddr)) viol <= viol + 1;
      if (w_hold && (!axi_wvalid || axi_wdata != hold_wdata || axi_wstrb != hold_wstrb)) viol <= viol + 1;
      if (ar_hold && (!axi_arvalid || axi_araddr != hold_araddr)) viol <= viol + 1;
      aw_hold <= axi_awvalid && !axi_awready;
      w_hold  <= axi_wvalid && !axi_wready;
      ar_hold <= axi_arvalid && !axi_arready;
      hold_awaddr <= axi_awaddr; hold_wdata <= axi_wdata;
      hold_wstrb  <= axi_wstrb;  hold_araddr <= axi_araddr;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_bad = 0;
  int model_errs = 0;
  logic [DW-1:0] last_wdata = '0;
  logic [SW-1:0] last_wstrb = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned model_lat(input txn_t t);
    if (t.we) return 3 + ((t.awd > t.wd) ? t.awd : t.wd) + t.bd;
    return 3 + t.ard + t.rd;
  endfunction

  function automatic int exp_errs();
    return (model_errs > 255) ? 255 : model_errs;
  endfunction

  task automatic run_txn(input txn_t t, input bit hold, input bit immediate);
    int unsigned waitc, k;
    int unsigned a0, w0, b0, ar0, r0;
    bit got;
    cur = t;
    a0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
    req_we = t.we; req_addr = t.addr; req_wdata = t.wdata; req_wstrb = t.wstrb;
    req_valid = 1'b1;
    waitc = 0;
    while (!req_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (immediate) chk("accept_in_resp_cycle", 64'(waitc), 0);
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: req_ready stayed 0, expected 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    chk("ready_after_accept", req_ready, 0);
    chk("resp_valid_after_accept", resp_valid, 0);
    chk("awvalid_start", axi_awvalid, t.we);
    chk("wvalid_start", axi_wvalid, t.we);
    chk("arvalid_start", axi_arvalid, !t.we);
    got = 0;
    for (k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (resp_valid) begin got = 1; break; end
      chk("ready_while_busy", req_ready, 0);
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL resp_timeout: resp_valid never rose, expected within %0d cycles", t.lat);
      req_valid = 1'b0;
      return;
    end
    chk("latency", 64'(k + 1), 64'(t.lat));
    if (t.resp[1]) model_errs++;
    chk("resp_err", resp_err, t.resp);
    chk("err_count", err_count, 64'(exp_errs()));
    chk("ready_at_resp", req_ready, 1);
    if (t.we) begin
      chk("aw_handshakes", 64'(n_aw - a0), 1);
      chk("w_handshakes", 64'(n_w - w0), 1);
      chk("b_handshakes", 64'(n_b - b0), 1);
      chk("ar_on_write", 64'(n_ar - ar0), 0);
      chk("awaddr", cap_awaddr, t.addr);
      chk("wdata", cap_wdata, t.wdata);
      chk("wstrb", cap_wstrb, t.wstrb);
      chk("awprot", cap_awprot, PROT_V);
      last_wdata = t.wdata;
      last_wstrb = t.wstrb;
    end else begin
      chk("ar_handshakes", 64'(n_ar - ar0), 1);
      chk("r_handshakes", 64'(n_r - r0), 1);
      chk("aw_on_read", 64'(n_aw - a0), 0);
      chk("araddr", cap_araddr, t.addr);
      chk("arprot", cap_arprot, PROT_V);
      chk("resp_rdata", resp_rdata, t.rdata);
      chk("wdata_kept_on_read", axi_wdata, last_wdata);
      chk("wstrb_kept_on_read", axi_wstrb, last_wstrb);
    end
    if (!hold) begin
      @(posedge clk); #1;
      chk("resp_pulse_single", resp_valid, 0);
    end
  endtask

  txn_t tbl [8];
  txn_t t;
  bit prev_hold, h;
  int unsigned nb0, nr0;

  initial begin
    cur = '{1'b0, '0, '0, '0, 0, 0, 0, 0, 0, 2'b00, '0, 0};
    tbl[0] = '{1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 3};
    tbl[1] = '{1'b1, 32'h1000_0008, 32'hCAFE_F00D, 4'h6, 0, 4, 0, 0, 0, 2'b00, 32'h0, 7};
    tbl[2] = '{1'b1, 32'h1000_000C, 32'h0BAD_C0DE, 4'h6, 4, 0, 0, 0, 0, 2'b00, 32'h0, 7};
    tbl[3] = '{1'b0, 32'h2000_0000, 32'h0, 4'h0, 0, 0, 0, 2, 0, 2'b00, 32'h1234_5678, 5};
    tbl[4] = '{1'b0, 32'h2000_0010, 32'h0, 4'h0, 0, 0, 0, 0, 3, 2'b01, 32'hA5A5_5A5A, 6};
    tbl[5] = '{1'b1, 32'h1000_0010, 32'h1357_2468, 4'h0, 1, 1, 2, 0, 0, 2'b00, 32'h0, 6};
    tbl[6] = '{1'b1, 32'h1000_0014, 32'hFFFF_0000, 4'hC, 2, 2, 0, 0, 0, 2'b10, 32'h0, 5};
    tbl[7] = '{1'b0, 32'h2000_0020, 32'h0, 4'h0, 0, 0, 0, 1, 1, 2'b11, 32'h89AB_CDEF, 5};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_wvalid", axi_wvalid, 0);
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_bready", axi_bready, 0);
    chk("rst_rready", axi_rready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_awaddr", axi_awaddr, 0);
    chk("rst_wdata", axi_wdata, 0);
    chk("rst_wstrb", axi_wstrb, 0);
    chk("rst_araddr", axi_araddr, 0);
    chk("rst_awprot", axi_awprot, PROT_V);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_req_ready", req_ready, 1);

    for (int i = 0; i < 8; i++) run_txn(tbl[i], 1'b0, 1'b0);

    // back-to-back: request held through resp_valid, next one accepted there
    t = '{1'b1, 32'h1000_0100, 32'h0102_0304, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 3};
    run_txn(t, 1'b1, 1'b0);
    t = '{1'b0, 32'h2000_0100, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h5566_7788, 3};
    run_txn(t, 1'b0, 1'b1);

    // stray B/R valids while idle must be ignored
    nb0 = n_b; nr0 = n_r;
    noise_b = 1'b1; noise_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_noise_no_resp", resp_valid, 0);
    end
    noise_b = 1'b0; noise_r = 1'b0;
    chk("idle_noise_no_b", 64'(n_b - nb0), 0);
    chk("idle_noise_no_r", 64'(n_r - nr0), 0);

    prev_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      t.we    = 1'($urandom_range(0, 1));
      t.addr  = $urandom;
      t.wdata = $urandom;
      t.wstrb = 4'($urandom_range(0, 15));
      t.awd   = $urandom_range(0, 3);
      t.wd    = $urandom_range(0, 3);
      t.bd    = $urandom_range(0, 3);
      t.ard   = $urandom_range(0, 3);
      t.rd    = $urandom_range(0, 3);
      t.resp  = 2'($urandom_range(0, 3));
      t.rdata = $urandom;
      t.lat   = model_lat(t);
      h = (i < 39) && ($urandom_range(0, 1) == 1);
      run_txn(t, h, prev_hold);
      prev_hold = h;
    end

    for (int i = 0; i < 300; i++) begin
      t = '{1'b0, 32'h3000_0000 + 32'(i * 4), 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, $urandom, 3};
      run_txn(t, 1'b0, 1'b0);
    end
    t = '{1'b1, 32'h3000_1000, 32'h7777_8888, 4'h3, 0, 0, 0, 0, 0, 2'b11, 32'h0, 3};
    run_txn(t, 1'b0, 1'b0);
    chk("err_count_saturated", err_count, 255);

    // reset while a write is stalled with awvalid high
    cur = '{1'b1, 32'h4000_0000, 32'h1111_2222, 4'hF, 5, 5, 0, 0, 0, 2'b00, 32'h0, 0};
    req_we = 1'b1; req_addr = 32'h4000_0000; req_wdata = 32'h1111_2222; req_wstrb = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_awvalid", axi_awvalid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_awvalid", axi_awvalid, 0);
    chk("midrst_wvalid", axi_wvalid, 0);
    chk("midrst_arvalid", axi_arvalid, 0);
    chk("midrst_bready", axi_bready, 0);
    chk("midrst_rready", axi_rready, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_awaddr", axi_awaddr, 0);
    model_errs = 0; last_wdata = '0; last_wstrb = '0;
    reset = 1'b0;
    t = '{1'b0, 32'h5000_0000, 32'h0, 4'h0, 0, 0, 0, 1, 0, 2'b00, 32'hFEED_FACE, 4};
    run_txn(t, 1'b0, 1'b0);

    chk("protocol_violations", 64'(viol), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_lite_manager_v2.md
Name: axi_lite_manager_v2

Overview:
- Parametrised AXI4-Lite manager bridging the RV32I core's memory port to the AXI4-Lite interconnect.
- Successor to the first-generation manager, adding:
  - a valid/ready request handshake;
  - byte strobes and a parameterised data width;
  - independent AW/W channel completion;
  - proper B/R response handshakes;
  - response-error reporting and a saturating error counter.
- One transaction outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, address width on the core and AXI sides.
- DATA_WIDTH, 32, data width; legal values are 32 and 64. STRB_WIDTH = DATA_WIDTH/8 is derived.
- PROT, 3'b000, constant value driven on axi_awprot and axi_arprot.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  the core presents a request.
- req_ready  out  1  the block accepts a request; combinational, high iff state==IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wstrb  in  STRB_WIDTH  write byte enables.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_WIDTH  read data; valid only with resp_valid on a read.
- resp_err  out  2  BRESP or RRESP of the completed transaction.
- err_count  out  ERR_CNT_WIDTH  count of responses with resp[1]==1; saturating.
- axi_awaddr out ADDR_WIDTH; axi_awprot out 3; axi_awvalid out 1; axi_awready in 1.
- axi_wdata out DATA_WIDTH; axi_wstrb out STRB_WIDTH; axi_wvalid out 1; axi_wready in 1.
- axi_bresp in 2; axi_bvalid in 1; axi_bready out 1.
- axi_araddr out ADDR_WIDTH; axi_arprot out 3; axi_arvalid out 1; axi_arready in 1.
- axi_rdata in DATA_WIDTH; axi_rresp in 2; axi_rvalid in 1; axi_rready out 1.

Behaviour:
- Reset (synchronous, reset=1 at the edge):
  - state=IDLE;
  - all *valid/*ready outputs=0;
  - resp_valid=0; resp_err=0; resp_rdata=0; err_count=0;
  - address/data/strobe registers=0.
  - Reset mid-transaction drops all valids immediately; the system resets the interconnect together with this block.
- States are IDLE, WRITE, WRITE_RESP, READ_ADDR and READ_RESP.
- IDLE:
  - On req_valid & req_ready, register addr, wdata and wstrb.
  - Write: awvalid=wvalid=1, clear aw_done/w_done, go to WRITE.
  - Read: arvalid=1, go to READ_ADDR.
- WRITE:
  - awvalid and wvalid each stay high until their own handshake, then drop the next cycle; aw_done/w_done record the completion.
  - The channels may complete in the same cycle or in either order.
  - When both are done (including same-cycle completion), go to WRITE_RESP with bready=1.
  - awaddr, wdata and wstrb are held stable while their valid is high.
- WRITE_RESP:
  - On bvalid & bready: bready=0, resp_err=bresp, resp_valid=1 for one cycle, state=IDLE.
- READ_ADDR:
  - On arready: arvalid=0, rready=1, go to READ_RESP.
- READ_RESP:
  - On rvalid & rready: rready=0, resp_rdata=rdata, resp_err=rresp, resp_valid=1 for one cycle, state=IDLE.
- Response latency: resp_valid is high in the cycle after the B/R handshake.
  - A new request may be accepted in the same cycle that resp_valid is high.
  - Minimum write: accept, AW+W, B, then resp = 3 cycles request-to-response.
  - Minimum read: same, 3 cycles.
- Valid outputs never depend combinationally on ready inputs; once asserted, a valid is not withdrawn before its handshake.
- Reads do not modify axi_wdata or axi_wstrb.
- err_count increments when resp_valid is set with resp_err[1]==1 (SLVERR or DECERR); it holds at all-ones.
- A write with req_wstrb=0 is legal and is issued unchanged.
- Inputs are ignored outside IDLE.
- Signals on an idle channel (bvalid, rvalid outside the RESP states) are ignored.

Test Plan:
- Write, addr=0x1000_0004, wdata=0xDEADBEEF, wstrb=4'hF; slave holds awready=wready=1 and returns bvalid the next cycle with OKAY → AW and W each handshake once; resp_valid pulses 3 cycles after acceptance; resp_err=0; err_count=0.
- Write with wready delayed 4 cycles after awready, then the reverse order → awvalid drops after its own handshake and wvalid holds for 4 cycles; exactly one B handshake; wstrb=4'b0110 appears on axi_wstrb.
- Read, addr=0x2000_0000; arready delayed 2 cycles; rdata=0x12345678 with rresp=OKAY → arvalid is held for 2 cycles; resp_rdata=0x12345678; resp_valid is a single-cycle pulse.
- Back-to-back write then read, with req_valid held through resp_valid → the second request is accepted in the resp_valid cycle; req_ready is low in all non-IDLE cycles.
- Error responses: 300 reads answered with rresp=2'b10 (SLVERR), then one write answered with 2'b11 (DECERR) → resp_err matches each response; err_count saturates at 255.
- Reset asserted while in WRITE with awvalid high → on the next edge all valids=0, state=IDLE, err_count=0, req_ready=1.
